mips_alu_mc: RTL and testbench
==============================

Name: mips_alu_mc

Overview:
- Parametrised, multi-cycle successor to the core 32-bit ALU.
- Width-generic datapath with an extended opcode set: XOR, NOR, true subtract, signed and unsigned compare, and shifts.
- Adds an iterative unsigned multiply/divide unit with architectural HI/LO registers.
- Sits in the EX stage behind a valid/ready handshake, so the pipeline stalls while multiply/divide iterates.

Parameters:
- WIDTH, 32, datapath width in bits; must be at least 4.
- SHAMT_W, 5, shift-amount width; must equal clog2(WIDTH).

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operation request.
- in_ready  output  1  unit can accept an operation this cycle.
- alu_op  input  4  operation select (see Behaviour).
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- out_valid  output  1  one-cycle pulse; result outputs valid.
- alu_out  output  WIDTH  registered result.
- carry_out  output  1  registered carry/no-borrow flag.
- overflow  output  1  registered signed-overflow flag.
- zero  output  1  registered flag, set when alu_out == 0.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE, in_ready=1, out_valid=0.
  - alu_out, hi, lo = 0; carry_out, overflow = 0; zero = 1.
  - Reset mid-multiply/divide aborts the operation: no out_valid pulse, HI/LO cleared.
- Accept rule: an operation is accepted when in_valid && in_ready at a clk edge. A, B and alu_op are sampled only at accept.
- Opcodes:
  - 0000 AND; 0001 OR; 0010 ADD; 0011 SLT (signed); 0100 XOR; 0101 NOR; 0110 SUB (A+~B+1); 0111 SLTU.
  - 1000 SLL: B << A[SHAMT_W-1:0].
  - 1001 SRL: B >> A[SHAMT_W-1:0], logical.
  - 1010 SRA: B >>> A[SHAMT_W-1:0], arithmetic.
  - 1011 reserved: result all ones, flags 0.
  - 1100 MULTU; 1101 DIVU; 1110 MFHI; 1111 MFLO.
- Flags:
  - carry_out = bit WIDTH of the WIDTH+1-bit sum, for ADD and SUB only. For SUB, 1 means no borrow (A >= B unsigned).
  - overflow = signed overflow, for ADD/SUB only.
  - Both flags are 0 for all other ops. zero is always derived from the registered alu_out.
- SLT/SLTU: result is 1 (zero-extended) or 0. SLT must give the correct result on signed overflow (e.g. min-negative vs positive).
- Single-cycle ops (all except 1100/1101): result registered at the accept edge; out_valid=1 for the following cycle. in_ready stays 1, so back-to-back accepts are allowed every cycle.
- FSM states: IDLE, MUL, DIV, FIN.
  - IDLE -> MUL on accepting MULTU.
  - IDLE -> DIV on accepting DIVU with B != 0.
  - IDLE -> FIN on accepting DIVU with B == 0.
  - MUL/DIV iterate one bit per cycle, using a log2(WIDTH)+1-bit counter, for WIDTH cycles, then go to FIN.
  - FIN writes hi/lo, drives out_valid=1 for one cycle, then returns to IDLE.
  - in_ready=0 in MUL, DIV and FIN.
- Multi-cycle latency: accept edge at cycle 0; out_valid high in cycle WIDTH+1; in_ready back to 1 in cycle WIDTH+2.
  - DIVU with B==0 (divide by zero): out_valid high in cycle 1.
- Results:
  - MULTU: {hi,lo} = A*B, full 2*WIDTH-bit unsigned product, shift-add.
  - DIVU: lo = A/B, hi = A%B, restoring division.
  - DIVU with B==0: lo = all ones, hi = A.
  - For MULTU/DIVU, alu_out = new lo value; carry_out and overflow = 0.
- hi/lo change only on a MULTU/DIVU completion or on reset.
- MFHI/MFLO return the current hi/lo. They can only issue in IDLE, so there is no read-during-update hazard.
- in_valid asserted while in_ready=0 is ignored; the requester holds its request.
- out_valid never asserts on a cycle with no completed operation.

Test Plan:
- WIDTH=32, reset: rst held 2 cycles -> alu_out=0, hi=lo=0, zero=1, in_ready=1, out_valid=0.
- ADD A=FFFFFFFF, B=1 -> next cycle out_valid=1, alu_out=0, carry_out=1, zero=1, overflow=0. ADD 7FFFFFFF+1 -> overflow=1.
- SUB 5-7 -> alu_out=FFFFFFFE, carry_out=0. SLT 80000000 vs 1 -> 1. SLTU 80000000 vs 1 -> 0. SRA A=4, B=80000000 -> F8000000.
- MULTU FFFFFFFF*FFFFFFFF -> out_valid exactly 33 cycles after accept, hi=FFFFFFFE, lo=00000001. in_ready=0 throughout; an in_valid ADD during this window is not accepted.
- DIVU 100/7 -> lo=14, hi=2 at cycle 33. DIVU 9/0 -> lo=FFFFFFFF, hi=9, out_valid at cycle 1. MFHI after either returns the hi value.
- rst asserted at cycle 10 of a MULTU -> no out_valid pulse, hi=lo=0, in_ready=1 on the next cycle. Repeat the MUL and DIV cases with WIDTH=8 (latency 9).

Source files
------------

// File: rtl/mips_alu_mc.sv
// mips_alu_mc: width-generic EX-stage ALU with an iterative unsigned
// multiply/divide unit and architectural HI/LO registers.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid / in_ready request handshake; A, B, alu_op sampled at accept
//   out_valid           one-cycle pulse, result outputs valid
//   alu_out             registered result
//   carry_out/overflow  registered ADD/SUB flags (0 for all other ops)
//   zero                alu_out == 0
//   hi, lo              HI/LO registers, written by MULTU/DIVU only
//
// WIDTH must be at least 4 and SHAMT_W must equal clog2(WIDTH).
//
// state | meaning
// IDLE  | ready; single-cycle ops complete here every cycle
// MUL   | shift-add multiply, one multiplier bit per cycle
// DIV   | restoring divide, one quotient bit per cycle
// FIN   | result committed, out_valid high, return to IDLE

module mips_alu_mc #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic [WIDTH-1:0] alu_out,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = SHAMT_W + 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

  localparam logic [3:0] OP_AND  = 4'h0, OP_OR   = 4'h1, OP_ADD  = 4'h2, OP_SLT  = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4, OP_NOR  = 4'h5, OP_SUB  = 4'h6, OP_SLTU = 4'h7;
  localparam logic [3:0] OP_SLL  = 4'h8, OP_SRL  = 4'h9, OP_SRA  = 4'hA, OP_RSVD = 4'hB;
  localparam logic [3:0] OP_MULT = 4'hC, OP_DIV  = 4'hD, OP_MFHI = 4'hE, OP_MFLO = 4'hF;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
  logic             accept, last_iter;

  assign in_ready  = (state == IDLE);
  assign accept    = in_valid && in_ready;
  assign last_iter = (cnt == CNT_W'(1));
  assign zero      = (alu_out == '0);

  // Single-cycle datapath
  logic [WIDTH:0]         sum_add, sum_sub;
  logic [SHAMT_W-1:0]     shamt;
  logic [WIDTH-1:0]       res;
  logic                   res_c, res_v;

  assign sum_add = {1'b0, A} + {1'b0, B};
  assign sum_sub = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
  assign shamt   = A[SHAMT_W-1:0];

  always_comb begin
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    case (alu_op)
      OP_AND:  res = A & B;
      OP_OR:   res = A | B;
      OP_ADD: begin
        res   = sum_add[WIDTH-1:0];
        res_c = sum_add[WIDTH];
        res_v = (A[WIDTH-1] == B[WIDTH-1]) && (sum_add[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_XOR:  res = A ^ B;
      OP_NOR:  res = ~(A | B);
      OP_SUB: begin
        res   = sum_sub[WIDTH-1:0];
        res_c = sum_sub[WIDTH];
        res_v = (A[WIDTH-1] != B[WIDTH-1]) && (sum_sub[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLTU: res = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_SLL:  res = B << shamt;
      OP_SRL:  res = B >> shamt;
      OP_SRA:  res = $signed(B) >>> shamt;
      OP_RSVD: res = '1;
      OP_MFHI: res = hi;
      OP_MFLO: res = lo;
      default: res = '0;
    endcase
  end

  // One shift-add step: conditionally add multiplicand to the upper half,
  // then shift the whole {acc_hi, acc_lo} pair right by one.
  logic [WIDTH:0]   mul_tmp;
  logic [WIDTH-1:0] mul_hi, mul_lo;

  assign mul_tmp = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
  assign mul_hi  = mul_tmp[WIDTH:1];
  assign mul_lo  = {mul_tmp[0], acc_lo[WIDTH-1:1]};

  // One restoring-divide step: acc_hi is the partial remainder, acc_lo the
  // dividend shifting out at the top while quotient bits enter at the bottom.
  // The shifted remainder is < 2*divisor, so when it fits the difference
  // is < divisor and the low WIDTH bits hold it exactly.
  logic [WIDTH:0]   div_shift;
  logic             div_ok;
  logic [WIDTH-1:0] div_diff, div_hi, div_lo;

  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ok    = (div_shift >= {1'b0, opnd});
  assign div_diff  = div_shift[WIDTH-1:0] - opnd;
  assign div_hi    = div_ok ? div_diff : div_shift[WIDTH-1:0];
  assign div_lo    = {acc_lo[WIDTH-2:0], div_ok};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && alu_op == OP_MULT)     state_nxt = MUL;
        else if (accept && alu_op == OP_DIV) state_nxt = (B == '0) ? FIN : DIV;
      end
      MUL, DIV: if (last_iter) state_nxt = FIN;
      FIN:      state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Multi-cycle results are committed on the edge into FIN so that
  // alu_out/hi/lo are already valid while out_valid is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      alu_out   <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      opnd      <= '0;
      cnt       <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (alu_op == OP_MULT || (alu_op == OP_DIV && B != '0)) begin
              acc_hi <= '0;
              acc_lo <= A;
              opnd   <= B;
              cnt    <= CNT_INIT;
            end else if (alu_op == OP_DIV) begin
              hi        <= A;
              lo        <= '1;
              alu_out   <= '1;
              carry_out <= 1'b0;
              overflow  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              alu_out   <= res;
              carry_out <= res_c;
              overflow  <= res_v;
              out_valid <= 1'b1;
            end
          end
        end
        MUL: begin
          acc_hi <= mul_hi;
          acc_lo <= mul_lo;
          cnt    <= cnt - CNT_W'(1);
          if (last_iter) begin
            hi        <= mul_hi;
            lo        <= mul_lo;
            alu_out   <= mul_lo;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        DIV: begin
          acc_hi <= div_hi;
          acc_lo <= div_lo;
          cnt    <= cnt - CNT_W'(1);
          if (last_iter) begin
            hi        <= div_hi;
            lo        <= div_lo;
            alu_out   <= div_lo;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_alu_mc.sv
module tb_mips_alu_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, out_valid, carry_out, overflow, zero;
  logic [3:0]  alu_op;
  logic [31:0] A, B, alu_out, hi, lo;

  logic        in_valid8, in_ready8, out_valid8, carry8, overflow8, zero8;
  logic [3:0]  alu_op8;
  logic [7:0]  a8, b8, alu_out8, hi8, lo8;

  mips_alu_mc #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .A(A), .B(B), .out_valid(out_valid), .alu_out(alu_out),
    .carry_out(carry_out), .overflow(overflow), .zero(zero), .hi(hi), .lo(lo)
  );

  mips_alu_mc #(.WIDTH(8), .SHAMT_W(3)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .alu_op(alu_op8), .A(a8), .B(b8), .out_valid(out_valid8), .alu_out(alu_out8),
    .carry_out(carry8), .overflow(overflow8), .zero(zero8), .hi(hi8), .lo(lo8)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  typedef struct packed {
    logic [31:0] res, hi, lo;
    logic c, v, z, pulse_after;
    int lat;
  } obs_t;

  typedef struct packed {
    logic [31:0] res, nhi, nlo;
    logic c, v;
    int lat;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, res;
    logic        c, v;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // Reference model from the operation definitions, using 64-bit arithmetic.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint          sa, sb, s, q;
    longint unsigned ua, ub, u, d;
    e = '0;
    e.nhi = m_hi;
    e.nlo = m_lo;
    e.lat = 1;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    d  = 64'd1 << a[4:0];
    case (op)
      4'h0: e.res = a & b;
      4'h1: e.res = a | b;
      4'h2: begin
        u = ua + ub; s = sa + sb;
        e.res = u[31:0]; e.c = u[32];
        e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'h3: e.res = (sa < sb) ? 32'd1 : 32'd0;
      4'h4: e.res = a ^ b;
      4'h5: e.res = ~(a | b);
      4'h6: begin
        u = ua - ub; s = sa - sb;
        e.res = u[31:0]; e.c = (ua >= ub);
        e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'h7: e.res = (ua < ub) ? 32'd1 : 32'd0;
      4'h8: begin u = ub * d; e.res = u[31:0]; end
      4'h9: begin u = ub / d; e.res = u[31:0]; end
      4'hA: begin
        q = (sb < 0) ? (sb - (longint'(d) - 1)) / longint'(d) : sb / longint'(d);
        e.res = q[31:0];
      end
      4'hB: e.res = 32'hFFFF_FFFF;
      4'hC: begin
        u = ua * ub;
        e.nhi = u[63:32]; e.nlo = u[31:0]; e.res = u[31:0]; e.lat = 33;
      end
      4'hD: begin
        if (b == 0) begin
          e.nhi = a; e.nlo = 32'hFFFF_FFFF;
        end else begin
          e.nhi = a % b; e.nlo = a / b; e.lat = 33;
        end
        e.res = e.nlo;
      end
      4'hE: e.res = m_hi;
      default: e.res = m_lo;
    endcase
    return e;
  endfunction

  // Called at a falling edge with the unit idle; returns at the falling edge
  // after the cycle following out_valid.
  task automatic apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output obs_t o);
    o = '0;
    chk("ready_before_issue", in_ready, 1);
    in_valid = 1'b1; alu_op = op; A = a; B = b;
    @(negedge clk);
    in_valid = 1'b0;
    o.lat = 1;
    while (!out_valid && o.lat < 80) begin
      @(negedge clk);
      o.lat++;
    end
    o.res = alu_out; o.hi = hi; o.lo = lo;
    o.c = carry_out; o.v = overflow; o.z = zero;
    @(negedge clk);
    o.pulse_after = out_valid;
  endtask

  task automatic apply8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] r, output logic [7:0] h, output logic [7:0] l, output int lat);
    in_valid8 = 1'b1; alu_op8 = op; a8 = a; b8 = b;
    @(negedge clk);
    in_valid8 = 1'b0;
    lat = 1;
    while (!out_valid8 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    r = alu_out8; h = hi8; l = lo8;
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[16];
    obs_t o;
    exp_t e;
    logic [3:0]  op;
    logic [31:0] ra, rb;
    logic [7:0]  r8, h8, l8;
    int          lat, bad_ready;
    logic        seen;

    vecs[0]  = '{4'h2, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};
    vecs[1]  = '{4'h2, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1};
    vecs[2]  = '{4'h6, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[3]  = '{4'h6, 32'h0000_0007, 32'h0000_0005, 32'h0000_0002, 1'b1, 1'b0};
    vecs[4]  = '{4'h6, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[5]  = '{4'h3, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0};
    vecs[6]  = '{4'h7, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0};
    vecs[7]  = '{4'h3, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0};
    vecs[8]  = '{4'hA, 32'h0000_0004, 32'h8000_0000, 32'hF800_0000, 1'b0, 1'b0};
    vecs[9]  = '{4'h9, 32'h0000_0004, 32'h8000_0000, 32'h0800_0000, 1'b0, 1'b0};
    vecs[10] = '{4'h8, 32'h0000_0025, 32'h0000_0001, 32'h0000_0020, 1'b0, 1'b0};
    vecs[11] = '{4'h0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0};
    vecs[12] = '{4'h1, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1'b0};
    vecs[13] = '{4'h4, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1'b0};
    vecs[14] = '{4'h5, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F, 1'b0, 1'b0};
    vecs[15] = '{4'hB, 32'h1234_5678, 32'h9ABC_DEF0, 32'hFFFF_FFFF, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; alu_op = '0; A = '0; B = '0;
    in_valid8 = 1'b0; alu_op8 = '0; a8 = '0; b8 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_alu_out", alu_out, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_zero", zero, 1);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_carry", carry_out, 0);
    chk("rst_overflow", overflow, 0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      apply(vecs[i].op, vecs[i].a, vecs[i].b, o);
      chk($sformatf("vec%0d_lat", i), o.lat, 1);
      chk($sformatf("vec%0d_res", i), o.res, vecs[i].res);
      chk($sformatf("vec%0d_carry", i), o.c, vecs[i].c);
      chk($sformatf("vec%0d_ovf", i), o.v, vecs[i].v);
      chk($sformatf("vec%0d_zero", i), o.z, (vecs[i].res == 0));
      chk($sformatf("vec%0d_pulse", i), o.pulse_after, 0);
    end

    // MULTU with a competing ADD request held for the whole window
    chk("mul_ready_before", in_ready, 1);
    in_valid = 1'b1; alu_op = 4'hC; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF;
    @(negedge clk);
    alu_op = 4'h2; A = 32'd1; B = 32'd1;
    lat = 1; bad_ready = 0;
    while (!out_valid && lat < 80) begin
      if (in_ready) bad_ready++;
      @(negedge clk);
      lat++;
    end
    if (in_ready) bad_ready++;
    chk("mul_latency", lat, 33);
    chk("mul_ready_low", bad_ready, 0);
    chk("mul_hi", hi, 32'hFFFF_FFFE);
    chk("mul_lo", lo, 32'h0000_0001);
    chk("mul_alu_out", alu_out, 32'h0000_0001);
    chk("mul_carry", carry_out, 0);
    @(negedge clk);
    chk("mul_ready_back", in_ready, 1);
    chk("mul_pulse_end", out_valid, 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("held_add_valid", out_valid, 1);
    chk("held_add_res", alu_out, 32'd2);
    m_hi = 32'hFFFF_FFFE; m_lo = 32'h0000_0001;
    @(negedge clk);

    apply(4'hD, 32'd100, 32'd7, o);
    chk("div_latency", o.lat, 33);
    chk("div_lo", o.lo, 32'd14);
    chk("div_hi", o.hi, 32'd2);
    chk("div_alu_out", o.res, 32'd14);
    m_hi = 32'd2; m_lo = 32'd14;
    apply(4'hE, 32'd0, 32'd0, o);
    chk("mfhi_after_div", o.res, 32'd2);

    apply(4'hD, 32'd9, 32'd0, o);
    chk("div0_latency", o.lat, 1);
    chk("div0_lo", o.lo, 32'hFFFF_FFFF);
    chk("div0_hi", o.hi, 32'd9);
    chk("div0_pulse", o.pulse_after, 0);
    m_hi = 32'd9; m_lo = 32'hFFFF_FFFF;
    apply(4'hE, 32'd0, 32'd0, o);
    chk("mfhi_after_div0", o.res, 32'd9);
    apply(4'hF, 32'd0, 32'd0, o);
    chk("mflo_after_div0", o.res, 32'hFFFF_FFFF);

    apply8(4'hC, 8'hFF, 8'hFF, r8, h8, l8, lat);
    chk("w8_mul_latency", lat, 9);
    chk("w8_mul_hi", h8, 8'hFE);
    chk("w8_mul_lo", l8, 8'h01);
    apply8(4'hD, 8'd100, 8'd7, r8, h8, l8, lat);
    chk("w8_div_latency", lat, 9);
    chk("w8_div_lo", l8, 8'd14);
    chk("w8_div_hi", h8, 8'd2);
    chk("w8_div_alu_out", r8, 8'd14);
    apply8(4'hD, 8'd9, 8'd0, r8, h8, l8, lat);
    chk("w8_div0_latency", lat, 1);
    chk("w8_div0_lo", l8, 8'hFF);
    chk("w8_div0_hi", h8, 8'd9);

    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = $urandom;
      if (op == 4'hD) begin
        rb = rb >> $urandom_range(0, 31);
        if ($urandom_range(0, 3) == 0) rb = '0;
      end
      e = model(op, ra, rb);
      apply(op, ra, rb, o);
      chk($sformatf("rnd%0d_op%0h_lat", i, op), o.lat, e.lat);
      chk($sformatf("rnd%0d_op%0h_res", i, op), o.res, e.res);
      chk($sformatf("rnd%0d_op%0h_carry", i, op), o.c, e.c);
      chk($sformatf("rnd%0d_op%0h_ovf", i, op), o.v, e.v);
      chk($sformatf("rnd%0d_op%0h_zero", i, op), o.z, (e.res == 0));
      chk($sformatf("rnd%0d_op%0h_hi", i, op), o.hi, e.nhi);
      chk($sformatf("rnd%0d_op%0h_lo", i, op), o.lo, e.nlo);
      chk($sformatf("rnd%0d_op%0h_pulse", i, op), o.pulse_after, 0);
      m_hi = e.nhi; m_lo = e.nlo;
    end

    // Make HI/LO non-zero, then abort a MULTU with reset at cycle 10
    apply(4'hD, 32'd9, 32'd0, o);
    chk("pre_abort_hi", o.hi, 32'd9);
    chk("abort_ready_before", in_ready, 1);
    in_valid = 1'b1; alu_op = 4'hC; A = 32'd3; B = 32'd5;
    @(negedge clk);
    in_valid = 1'b0;
    seen = out_valid;
    for (int c = 2; c <= 10; c++) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    chk("abort_alu_out", alu_out, 0);
    chk("abort_zero", zero, 1);
    repeat (40) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    chk("abort_no_pulse", seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
